// File: rtl/minimac2_mdio_slave.sv
// minimac2_mdio_slave
// PHY-side responder for clause 22 MII management frames (MDC/MDIO).
// Decodes frames from the station-side master and maps them onto a
// single-cycle register port. Everything runs on sys_clk, and MDC is
// sampled as data. Read data is returned on MDIO.
//
// Ports:
//   sys_clk, sys_rst_n   system clock, asynchronous active-low reset
//   mdc, mdio_i          management clock and MDIO pad input (asynchronous)
//   mdio_o, mdio_oe      MDIO pad output value and output enable
//   reg_re, reg_we       one-cycle read request / write strobe
//   reg_adr              REGAD of the current frame
//   reg_dat_w            write data, valid with reg_we
//   reg_dat_r            read data, sampled 2 cycles after reg_re
//   busy                 high while a frame for phy_addr is in progress
//
// Build option: define MINIMAC2_MDIO_PREAMBLE_SUPPRESSION_EN to accept a
// shortened preamble (>= 1 one) directly after a completed frame.
`timescale 1ns/1ps
module minimac2_mdio_slave #(
  parameter logic [4:0] phy_addr = 5'd0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        reg_re,
  output logic        reg_we,
  output logic [4:0]  reg_adr,
  output logic [15:0] reg_dat_w,
  input  logic [15:0] reg_dat_r,
  output logic        busy
);

`ifdef MINIMAC2_MDIO_PREAMBLE_SUPPRESSION_EN
  localparam logic sup_en = 1'b1;
`else
  localparam logic sup_en = 1'b0;
`endif

  typedef enum logic [1:0] {ST_PRE, ST_HDR, ST_DATA} state_t;

  logic        mdc_s1_reg, mdc_s2_reg, mdc_prev_reg;
  logic        mdio_s1_reg, mdio_s2_reg;
  logic        rise, fall, bit_in;

  state_t      state_reg, state_next;
  logic [5:0]  pre_cnt_reg, pre_cnt_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;   // number of the last bit that rose
  logic [12:0] hdr_sr_reg, hdr_sr_next;
  logic [14:0] dat_sr_reg, dat_sr_next;
  logic [15:0] rd_data_reg, rd_data_next;
  logic        is_read_reg, is_read_next;
  logic        sup_flag_reg, sup_flag_next;
  logic        re_d1_reg, re_d2_reg;

  logic        mdio_o_next, mdio_oe_next, reg_re_next, reg_we_next, busy_next;
  logic [4:0]  reg_adr_next;
  logic [15:0] reg_dat_w_next;

  logic [13:0] hdr_full;
  logic        hdr_ok, start_ok;
  logic [4:0]  bit_cur;
  logic [3:0]  rd_idx;

  assign rise   = mdc_s2_reg & ~mdc_prev_reg;
  assign fall   = ~mdc_s2_reg & mdc_prev_reg;
  assign bit_in = mdio_s2_reg;

  // Bits 0..13 MSB first: ST[13:12] OP[11:10] PHYAD[9:5] REGAD[4:0]
  assign hdr_full = {hdr_sr_reg, bit_in};
  assign hdr_ok   = (hdr_full[13:12] == 2'b01) &&
                    ((hdr_full[11:10] == 2'b10) || (hdr_full[11:10] == 2'b01)) &&
                    (hdr_full[9:5] == phy_addr);
  assign start_ok = (pre_cnt_reg == 6'd32) ||
                    (sup_en && sup_flag_reg && (pre_cnt_reg != 6'd0));
  assign bit_cur  = bit_cnt_reg + 5'd1;
  // Fall after bit N (15..30) drives data bit 30-N; modulo 16 that is 14-N.
  assign rd_idx   = 4'd14 - bit_cnt_reg[3:0];

  always_comb begin
    state_next     = state_reg;
    pre_cnt_next   = pre_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    hdr_sr_next    = hdr_sr_reg;
    dat_sr_next    = dat_sr_reg;
    rd_data_next   = rd_data_reg;
    is_read_next   = is_read_reg;
    sup_flag_next  = sup_flag_reg;
    mdio_o_next    = mdio_o;
    mdio_oe_next   = mdio_oe;
    reg_re_next    = 1'b0;
    reg_we_next    = 1'b0;
    reg_adr_next   = reg_adr;
    reg_dat_w_next = reg_dat_w;
    busy_next      = busy;

    if (re_d2_reg) rd_data_next = reg_dat_r;

    case (state_reg)
      ST_PRE: begin
        if (rise) begin
          if (bit_in) begin
            if (pre_cnt_reg != 6'd32) pre_cnt_next = pre_cnt_reg + 6'd1;
          end else if (start_ok) begin
            // This 0 is ST bit 0; it is implied by the cleared shift register.
            state_next   = ST_HDR;
            bit_cnt_next = 5'd0;
            hdr_sr_next  = 13'd0;
            pre_cnt_next = 6'd0;
          end else begin
            pre_cnt_next = 6'd0;
          end
        end
      end

      ST_HDR: begin
        if (rise) begin
          hdr_sr_next  = hdr_full[12:0];
          bit_cnt_next = bit_cur;
          if (bit_cur == 5'd13) begin
            if (hdr_ok) begin
              state_next   = ST_DATA;
              busy_next    = 1'b1;
              reg_adr_next = hdr_full[4:0];
              is_read_next = (hdr_full[11:10] == 2'b10);
              reg_re_next  = (hdr_full[11:10] == 2'b10);
            end else begin
              state_next    = ST_PRE;
              pre_cnt_next  = 6'd0;
              sup_flag_next = 1'b0;
            end
          end
        end
      end

      ST_DATA: begin
        if (is_read_reg) begin
          if (rise && (bit_cnt_reg != 5'd31)) bit_cnt_next = bit_cur;
          if (fall) begin
            if (bit_cnt_reg == 5'd14) begin
              mdio_oe_next = 1'b1;
              mdio_o_next  = 1'b0;
            end else if (bit_cnt_reg == 5'd31) begin
              mdio_oe_next  = 1'b0;
              mdio_o_next   = 1'b0;
              busy_next     = 1'b0;
              state_next    = ST_PRE;
              pre_cnt_next  = 6'd0;
              sup_flag_next = 1'b1;
            end else if (bit_cnt_reg >= 5'd15) begin
              mdio_o_next = rd_data_reg[rd_idx];
            end
          end
        end else if (rise) begin
          bit_cnt_next = bit_cur;
          if (bit_cur == 5'd31) begin
            reg_we_next    = 1'b1;
            reg_dat_w_next = {dat_sr_reg, bit_in};
            busy_next      = 1'b0;
            state_next     = ST_PRE;
            pre_cnt_next   = 6'd0;
            sup_flag_next  = 1'b1;
          end else if (bit_cur >= 5'd16) begin
            dat_sr_next = {dat_sr_reg[13:0], bit_in};
          end
        end
      end

      default: begin
        state_next   = ST_PRE;
        pre_cnt_next = 6'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mdc_s1_reg   <= 1'b0;
      mdc_s2_reg   <= 1'b0;
      mdc_prev_reg <= 1'b0;
      mdio_s1_reg  <= 1'b0;
      mdio_s2_reg  <= 1'b0;
      state_reg    <= ST_PRE;
      pre_cnt_reg  <= 6'd0;
      bit_cnt_reg  <= 5'd0;
      hdr_sr_reg   <= 13'd0;
      dat_sr_reg   <= 15'd0;
      rd_data_reg  <= 16'd0;
      is_read_reg  <= 1'b0;
      sup_flag_reg <= 1'b0;
      re_d1_reg    <= 1'b0;
      re_d2_reg    <= 1'b0;
      mdio_o       <= 1'b0;
      mdio_oe      <= 1'b0;
      reg_re       <= 1'b0;
      reg_we       <= 1'b0;
      reg_adr      <= 5'd0;
      reg_dat_w    <= 16'd0;
      busy         <= 1'b0;
    end else begin
      mdc_s1_reg   <= mdc;
      mdc_s2_reg   <= mdc_s1_reg;
      mdc_prev_reg <= mdc_s2_reg;
      mdio_s1_reg  <= mdio_i;
      mdio_s2_reg  <= mdio_s1_reg;
      state_reg    <= state_next;
      pre_cnt_reg  <= pre_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      hdr_sr_reg   <= hdr_sr_next;
      dat_sr_reg   <= dat_sr_next;
      rd_data_reg  <= rd_data_next;
      is_read_reg  <= is_read_next;
      sup_flag_reg <= sup_flag_next;
      re_d1_reg    <= reg_re;
      re_d2_reg    <= re_d1_reg;
      mdio_o       <= mdio_o_next;
      mdio_oe      <= mdio_oe_next;
      reg_re       <= reg_re_next;
      reg_we       <= reg_we_next;
      reg_adr      <= reg_adr_next;
      reg_dat_w    <= reg_dat_w_next;
      busy         <= busy_next;
    end
  end

endmodule
